// File: rtl/fifo_rd_pkg.sv
// Shared types for the FIFO burst reader.
// State encoding and output buffer sizing.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int BUF_DEPTH = 2;
  localparam int CW        = $clog2(BUF_DEPTH + 1);

  // Occupancy after this cycle, counting the word still in flight.
  function automatic logic has_room(
    input logic [CW-1:0] cnt,
    input logic          infl,
    input logic          pop
  );
    logic [CW:0] occ;
    occ = {1'b0, cnt} + {{CW{1'b0}}, infl}
        - {{CW{1'b0}}, pop};
    return occ < (CW+1)'(BUF_DEPTH);
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry register buffer feeding a valid/ready stream.
// Entry 0 is always the head; it only moves on a pop.
module stream_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int DWIDTH = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic [DWIDTH-1:0] i_data,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DWIDTH-1:0] o_data,
  output logic [CW-1:0]     o_count
);

  logic [DWIDTH-1:0] r_d0;
  logic [DWIDTH-1:0] r_d1;
  logic [CW-1:0]     r_cnt;
  logic              w_pop;

  assign o_valid = (r_cnt != '0);
  assign o_data  = r_d0;
  assign o_count = r_cnt;
  assign w_pop   = o_valid & i_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_d0  <= '0;
      r_d1  <= '0;
      r_cnt <= '0;
    end else begin
      unique case ({i_push, w_pop})
        2'b10: begin
          if (r_cnt == '0) r_d0 <= i_data;
          else             r_d1 <= i_data;
          r_cnt <= r_cnt + CW'(1);
        end
        2'b01: begin
          r_d0  <= r_d1;
          r_cnt <= r_cnt - CW'(1);
        end
        2'b11: begin
          if (r_cnt == CW'(1)) begin
            r_d0 <= i_data;
          end else begin
            r_d0 <= r_d1;
            r_d1 <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Command-driven burst reader: drains a sync FIFO
// into a valid/ready stream with last/done marking.
module fifo_burst_reader
  import fifo_rd_pkg::*;
#(
  parameter int DWIDTH = 16,
  parameter int LWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LWIDTH-1:0] cmd_len,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DWIDTH-1:0] fifo_dout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DWIDTH-1:0] m_data,
  output logic              m_last,
  output logic              done,
  output logic              busy
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [LWIDTH-1:0] r_issue_cnt;
  logic [LWIDTH-1:0] r_beat_cnt;
  logic              r_inflight;
  logic              r_done;

  logic              w_accept;
  logic              w_rd;
  logic              w_pop;
  logic              w_last_pop;
  logic              w_done_nxt;
  logic              w_buf_valid;
  logic [DWIDTH-1:0] w_buf_data;
  logic [CW-1:0]     w_buf_cnt;

  stream_skid_buf #(
    .DWIDTH (DWIDTH)
  ) u_buf (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (r_inflight),
    .i_data  (fifo_dout),
    .i_ready (m_ready),
    .o_valid (w_buf_valid),
    .o_data  (w_buf_data),
    .o_count (w_buf_cnt)
  );

  // Outputs are forced quiet for the whole reset cycle.
  assign m_valid = w_buf_valid & ~rst;
  assign m_data  = rst ? '0 : w_buf_data;
  assign m_last  = m_valid & (r_beat_cnt == LWIDTH'(1));
  assign done    = r_done & ~rst;
  assign busy    = (r_state != IDLE) & ~rst;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    cmd_ready   = 1'b0;
    w_pop       = m_valid & m_ready;
    w_last_pop  = w_pop & (r_beat_cnt == LWIDTH'(1));
    w_rd        = 1'b0;
    w_accept    = 1'b0;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      IDLE: begin
        cmd_ready = ~rst;
        w_accept  = cmd_valid & ~rst;
        if (w_accept) begin
          if (cmd_len != '0) w_state_nxt = RUN;
          else               w_done_nxt  = 1'b1;
        end
      end
      RUN: begin
        w_rd = ~rst & ~fifo_empty
             & (r_issue_cnt != '0)
             & has_room(w_buf_cnt, r_inflight,
                        w_pop);
        if (w_rd && r_issue_cnt == LWIDTH'(1))
          w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (w_last_pop) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign fifo_rd_en = w_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_issue_cnt <= '0;
      r_beat_cnt  <= '0;
      r_inflight  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_inflight <= w_rd;
      r_done     <= w_done_nxt;
      if (w_accept) begin
        r_issue_cnt <= cmd_len;
        r_beat_cnt  <= cmd_len;
      end else begin
        if (w_rd && r_issue_cnt != '0)
          r_issue_cnt <= r_issue_cnt - LWIDTH'(1);
        if (w_pop && r_beat_cnt != '0)
          r_beat_cnt <= r_beat_cnt - LWIDTH'(1);
      end
    end
  end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Read-side master for the team's sync FIFO: drains the FIFO read port (rd_en/dout/empty) and presents the words as a valid/ready output stream.
- Bursts are command-driven: one command gives a length; the block reads exactly that many words, flags the final one with m_last and pulses done.
- Absorbs the FIFO's one-cycle registered read latency with a 2-entry output buffer, so sustained throughput is 1 word/cycle under m_ready backpressure.

Parameters:
- DWIDTH, 16, data width; must match the FIFO's data width.
- LWIDTH, 8, width of cmd_len; maximum burst is 2^LWIDTH-1 words.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- cmd_valid  input  1  burst command present
- cmd_ready  output  1  block can accept a command (high only in IDLE and rst low)
- cmd_len  input  LWIDTH  number of words in the burst; sampled on cmd_valid&cmd_ready
- fifo_empty  input  1  FIFO empty flag
- fifo_rd_en  output  1  FIFO read enable; never asserted while fifo_empty=1
- fifo_dout  input  DWIDTH  FIFO read data, valid the cycle after fifo_rd_en
- m_valid  output  1  output word valid
- m_ready  input  1  downstream accepts word
- m_data  output  DWIDTH  output word
- m_last  output  1  high with the final word of the burst
- done  output  1  one-cycle pulse at burst completion
- busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset: state=IDLE, counters=0, buffer empty, inflight=0. fifo_rd_en=0, m_valid=0, m_last=0, m_data=0, done=0, busy=0, cmd_ready=0 while rst=1.
- Reset mid-burst aborts immediately. A word already read from the FIFO (inflight) is discarded. The FIFO is not rewound.
- States:
  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready, load issue_cnt=beat_cnt=cmd_len.
    - cmd_len!=0: go to RUN.
    - cmd_len==0: pulse done next cycle, stay in IDLE, no data moved.
  - RUN: issue reads. When issue_cnt reaches 0 after a read, go to DRAIN.
  - DRAIN: wait until beat_cnt reaches 0 at a handshake. Then pulse done in the next cycle and return to IDLE in that same cycle.
- Read issue rule: fifo_rd_en = (state==RUN) & !fifo_empty & (issue_cnt!=0) & (buf_cnt + inflight - pop < 2).
  - pop = m_valid & m_ready.
  - inflight is the registered value of fifo_rd_en.
- Capture: when inflight=1, fifo_dout is written into the buffer tail at the next edge.
- Output: m_data/m_valid come from the buffer head. m_data and m_last must be held stable while m_valid & !m_ready.
- m_last = m_valid & (beat_cnt==1). beat_cnt decrements on each pop.
- Latency:
  - Command accepted at edge 0; first fifo_rd_en in cycle 1 if FIFO non-empty.
  - fifo_dout valid in cycle 2; m_valid first high in cycle 3.
  - done high the cycle after the final handshake; cmd_ready high again that same cycle.
- Throughput: with m_ready=1 and FIFO non-empty, one word per cycle, with no bubbles after the first word.
- FIFO empty mid-burst: stall issue, no error. Resume on the first non-empty cycle.
- Backpressure: with m_ready=0, at most 2 words are buffered. Reads stop until a pop frees space; the pop credit lets a read issue in the same cycle as the pop.
- Width rules: counters are LWIDTH bits and decrement only when non-zero, so there is no wrap.
- Commands arriving while busy are not accepted, since cmd_ready=0.

Decomposition:
- Shared package fifo_rd_pkg holds:
  - state typedef {IDLE, RUN, DRAIN}, 2 bits;
  - localparam BUF_DEPTH=2.
- One sub-module, stream_skid_buf: 2-entry register buffer with push/pop, valid/ready out, and a count output used by the issue rule.

Test Plan:
- Basic burst: FIFO preloaded 0x0001..0x0004, cmd_len=4, m_ready=1.
  - Expect 4 beats 0x0001..0x0004 on consecutive cycles, m_last only on 0x0004.
  - Expect done one cycle after the last beat, first m_valid 3 cycles after command accept.
- Backpressure: FIFO holds 6 words, cmd_len=6, m_ready toggling 1,0,0,1...
  - Expect no loss or duplication and m_data stable while stalled.
  - Expect fifo_rd_en never raised with 2 words buffered and no pop.
- Underflow stall: FIFO holds 2 words, cmd_len=5. After 10 idle cycles, write 3 more words.
  - Expect 2 beats, then m_valid=0 with busy=1, then 3 beats, m_last on the fifth, done.
- Zero-length command: cmd_len=0 → done pulse next cycle, fifo_rd_en never asserted, m_valid stays 0.
- Reset mid-burst: cmd_len=8, assert rst after 3 beats.
  - Next cycle: m_valid=0, busy=0, done=0.
  - After rst release: cmd_ready=1, and a new cmd_len=2 reads the next 2 FIFO words correctly.
- Back-to-back commands: cmd_valid held high with lengths 3 then 2.
  - Second command accepted the cycle done pulses.
  - m_last on beat 3 and beat 5; two done pulses.
